chart_sequencer: RTL and testbench

- Walks the 4-lane chart ROM (11-bit address, 4-bit row, one bit per lane) at a fixed row rate.
- Compensates for the ROM read latency and emits one-cycle note-spawn pulses per lane to the downstream note/lane renderer.
- Sits directly downstream of the chart ROM and upstream of the note-falling logic.
- Address 0 is a reserved header; chart rows occupy addresses 1..MAX_ADDR.

---
 rtl/chart_pkg.sv | 19 +
 rtl/chart_sequencer_tick.sv | 43 ++++
 rtl/chart_sequencer.sv | 149 ++++++++++++++
 tb/tb_chart_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chart_pkg.sv
// Shared constants and state encoding for the chart playback path.
package chart_pkg;

  localparam int CHART_ADDR_W     = 11;
  localparam int LANES            = 4;
  localparam int CHART_FIRST_ADDR = 1;
  localparam int CHART_LAST_ADDR  = 2000;

  // Sequencer phases: waiting for start, waiting for the row tick, waiting
  // out the ROM latency, presenting the row, and finished.
  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    WAIT_DATA,
    EMIT,
    DONE
  } chart_state_e;

endpackage

// File: rtl/chart_sequencer_tick.sv
// Row-rate divider: counts clocks while enabled and flags the start of each row period.
module row_tick_gen #(
  parameter int TICK_DIV = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear restarts the row phase, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register; holding while disabled is what preserves phase across a pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/chart_sequencer.sv
// Chart sequencer: steps through chart ROM rows at the row rate, hides the ROM
// read latency and emits one-cycle per-lane note-spawn pulses.
module chart_sequencer
  import chart_pkg::*;
#(
  parameter int ADDR_WIDTH  = CHART_ADDR_W,
  parameter int DATA_WIDTH  = LANES,
  parameter int MAX_ADDR    = CHART_LAST_ADDR,
  parameter int TICK_DIV    = 1250000,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] lane_spawn,
  output logic                  row_valid,
  output logic [ADDR_WIDTH-1:0] row_index,
  output logic                  playing,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ROW = ADDR_WIDTH'(CHART_FIRST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(MAX_ADDR);
  // Latency is 1 or 2, so a 2-bit counter always suffices.
  localparam logic [1:0]            LAT_LAST  = 2'(ROM_LATENCY - 1);

  chart_state_e          state_q,      state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q,   rom_addr_d;
  logic [DATA_WIDTH-1:0] lane_spawn_q, lane_spawn_d;
  logic                  row_valid_q,  row_valid_d;
  logic [ADDR_WIDTH-1:0] row_index_q,  row_index_d;
  logic                  playing_q,    playing_d;
  logic                  done_q,       done_d;
  logic [1:0]            lat_cnt_q,    lat_cnt_d;

  logic start_ok;
  logic tick_enable;
  logic tick;

  // Start is only honoured when nothing is playing, so a mid-chart pulse cannot
  // rewind the address under an in-flight read.
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign tick_enable = playing_q && !pause;

  row_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .enable (tick_enable),
    .tick   (tick)
  );

  // Next-state and next-output logic for the whole playback sequence.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    lane_spawn_d = '0;
    row_valid_d  = 1'b0;
    row_index_d  = row_index_q;
    playing_d    = playing_q;
    done_d       = done_q;
    lat_cnt_d    = lat_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = PLAY;
          rom_addr_d = FIRST_ROW;
          playing_d  = 1'b1;
          done_d     = 1'b0;
          lat_cnt_d  = '0;
        end
      end

      PLAY: begin
        // The address is already on the ROM; the tick marks when this row's read counts.
        if (tick) begin
          state_d   = WAIT_DATA;
          lat_cnt_d = '0;
        end
      end

      WAIT_DATA: begin
        if (lat_cnt_q == LAT_LAST) begin
          lane_spawn_d = rom_data;
          row_valid_d  = 1'b1;
          row_index_d  = rom_addr_q;
          state_d      = EMIT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      EMIT: begin
        // Stop on the last row instead of advancing so the address never wraps.
        if (rom_addr_q == LAST_ROW) begin
          state_d   = DONE;
          playing_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered together; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= FIRST_ROW;
      lane_spawn_q <= '0;
      row_valid_q  <= 1'b0;
      row_index_q  <= '0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      lane_spawn_q <= lane_spawn_d;
      row_valid_q  <= row_valid_d;
      row_index_q  <= row_index_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_en     = playing_q;
  assign lane_spawn = lane_spawn_q;
  assign row_valid  = row_valid_q;
  assign row_index  = row_index_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: two instances (ROM latency 1 and 2) share stimulus,
// each checked every cycle against a schedule-based model plus emit-time tables.
module tb_chart_sequencer;

  localparam int AW   = 11;
  localparam int DW   = 4;
  localparam int MAXA = 5;
  localparam int DIV  = 4;

  localparam logic [29:0] RESET_OUT = {11'd1, 1'b0, 4'd0, 1'b0, 11'd0, 1'b0, 1'b0};

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic chk_en = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Chart contents used by the ROM models (address 0 is the header).
  function automatic logic [3:0] chart_row(input int a);
    case (a)
      1: chart_row = 4'h1;
      2: chart_row = 4'h2;
      3: chart_row = 4'h0;
      4: chart_row = 4'hF;
      5: chart_row = 4'h8;
      default: chart_row = 4'hA;
    endcase
  endfunction

  logic [AW-1:0] rom_addr1, rom_addr2, row_index1, row_index2;
  logic          rom_en1, rom_en2, row_valid1, row_valid2;
  logic          playing1, playing2, done1, done2;
  logic [DW-1:0] rom_data1 = '0, rom_data2 = '0, rom_stage2 = '0;
  logic [DW-1:0] lane_spawn1, lane_spawn2;

  chart_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ADDR(MAXA),
                    .TICK_DIV(DIV), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .rom_addr(rom_addr1), .rom_en(rom_en1), .rom_data(rom_data1),
    .lane_spawn(lane_spawn1), .row_valid(row_valid1), .row_index(row_index1),
    .playing(playing1), .done(done1));

  chart_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ADDR(MAXA),
                    .TICK_DIV(DIV), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
    .lane_spawn(lane_spawn2), .row_valid(row_valid2), .row_index(row_index2),
    .playing(playing2), .done(done2));

  // Block-RAM style ROMs: one and two clocks from address to data.
  always @(posedge clk) begin
    if (rom_en1) rom_data1 <= chart_row(int'(rom_addr1));
    if (rom_en2) rom_stage2 <= chart_row(int'(rom_addr2));
    rom_data2 <= rom_stage2;
  end

  logic [29:0] out1, out2;
  assign out1 = {rom_addr1, rom_en1, lane_spawn1, row_valid1, row_index1, playing1, done1};
  assign out2 = {rom_addr2, rom_en2, lane_spawn2, row_valid2, row_index2, playing2, done2};

  // Reference model: tracks the row phase as a plain modulo counter and schedules
  // each row's emit edge as issue edge + latency.
  typedef struct packed {
    logic       playing;
    logic       done;
    logic       busy;
    int         row;
    int         phase;
    int         emit_edge;
    logic [3:0] spawn;
    logic       valid;
    int         index;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    m.row = 1;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic st, logic pz, int e, int lat);
    model_t n;
    n = m;
    n.valid = 1'b0;
    n.spawn = 4'h0;
    if (st && !m.playing) begin
      n.playing = 1'b1;
      n.done = 1'b0;
      n.row = 1;
      n.phase = 0;
      n.busy = 1'b0;
      return n;
    end
    if (m.playing) begin
      if (m.busy && e == m.emit_edge) begin
        n.valid = 1'b1;
        n.spawn = chart_row(m.row);
        n.index = m.row;
      end
      if (m.busy && e == m.emit_edge + 1) begin
        n.busy = 1'b0;
        if (m.row == MAXA) begin
          n.playing = 1'b0;
          n.done = 1'b1;
        end else begin
          n.row = m.row + 1;
        end
      end
      if (!m.busy && m.phase == 0 && !pz) begin
        n.busy = 1'b1;
        n.emit_edge = e + lat;
      end
      if (!pz) n.phase = (m.phase + 1) % DIV;
    end
    return n;
  endfunction

  function automatic logic [29:0] model_out(model_t m);
    return {AW'(m.row), m.playing, m.spawn, m.valid, AW'(m.index), m.playing, m.done};
  endfunction

  model_t m1, m2;
  int edge_no = 0;
  int start_edge = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = model_reset();
      m2 = model_reset();
    end else begin
      edge_no++;
      if (start && !m1.playing) start_edge = edge_no;
      m1 = model_step(m1, start, pause, edge_no, 1);
      m2 = model_step(m2, start, pause, edge_no, 2);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("dut1 cycle", 64'(out1), 64'(model_out(m1)));
      checkOutput("dut2 cycle", 64'(out2), 64'(model_out(m2)));
    end
  end

  // Emit log: offset from accepted start edge, lanes, row index.
  typedef struct packed {
    int         off;
    logic [3:0] sp;
    logic [10:0] idx;
  } emit_t;

  emit_t log1[$];
  emit_t log2[$];

  always @(negedge clk) begin
    if (row_valid1) log1.push_back({edge_no - start_edge, lane_spawn1, row_index1});
    if (row_valid2) log2.push_back({edge_no - start_edge, lane_spawn2, row_index2});
  end

  emit_t tbl_plain[5];
  emit_t tbl_pause[5];

  task automatic checkEmits(input string name, input int which, input bit use_pause, input int shift);
    emit_t exp;
    emit_t act;
    int n;
    n = (which == 1) ? log1.size() : log2.size();
    checkOutput($sformatf("%s emit count", name), 64'(n), 64'd5);
    for (int i = 0; i < 5; i++) begin
      exp = use_pause ? tbl_pause[i] : tbl_plain[i];
      exp.off = exp.off + shift;
      if (i < n) act = (which == 1) ? log1[i] : log2[i];
      else act = {-1, 4'h0, 11'h0};
      checkOutput($sformatf("%s row %0d", name, i + 1), 64'(act), 64'(exp));
    end
  endtask

  task automatic applyStimulus(input logic st, input logic pz);
    start = st;
    pause = pz;
    @(negedge clk);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic clearLogs();
    log1.delete();
    log2.delete();
  endtask

  initial begin
    int plain_off[5];
    int pause_off[5];
    logic [3:0] lanes[5];
    logic pz;
    plain_off = '{2, 6, 10, 14, 18};
    pause_off = '{2, 6, 18, 22, 26};
    lanes     = '{4'h1, 4'h2, 4'h0, 4'hF, 4'h8};
    for (int i = 0; i < 5; i++) begin
      tbl_plain[i] = {plain_off[i], lanes[i], 11'(i + 1)};
      tbl_pause[i] = {pause_off[i], lanes[i], 11'(i + 1)};
    end

    m1 = model_reset();
    m2 = model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset state dut1", 64'(out1), 64'(RESET_OUT));
    checkOutput("reset state dut2", 64'(out2), 64'(RESET_OUT));
    rst = 1'b0;
    runIdle(3);

    // Plain playback; latency-2 instance trails by one cycle.
    $display("[TB] scenario: playback from IDLE");
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    runIdle(24);
    checkEmits("s1 lat1", 1, 1'b0, 0);
    checkEmits("s6 lat2", 2, 1'b0, 1);
    checkOutput("s1 end state", 64'({done1, playing1, rom_en1, rom_addr1}), 64'({1'b1, 1'b0, 1'b0, 11'd5}));

    // Restart from DONE.
    $display("[TB] scenario: restart from DONE");
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    checkOutput("s4 done falls", 64'({done1, done2, playing1, playing2}), 64'(4'b0011));
    runIdle(24);
    checkEmits("s4 lat1", 1, 1'b0, 0);
    checkEmits("s4 lat2", 2, 1'b0, 1);

    // Start pulsed during playback is ignored.
    $display("[TB] scenario: start during playback");
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    runIdle(2);
    applyStimulus(1'b1, 1'b0);
    runIdle(22);
    checkEmits("s3 lat1", 1, 1'b0, 0);
    checkEmits("s3 lat2", 2, 1'b0, 1);

    // Pause for 8 cycles right after row 2's read issues.
    $display("[TB] scenario: pause after row 2 issue");
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    runIdle(5);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
    runIdle(20);
    checkEmits("s2 lat1", 1, 1'b1, 0);
    checkEmits("s2 lat2", 2, 1'b1, 1);

    // Async reset while row 3 is in flight.
    $display("[TB] scenario: reset during row 3 read");
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    runIdle(9);
    #1 rst = 1'b1;
    #1;
    checkOutput("s5 async reset dut1", 64'(out1), 64'(RESET_OUT));
    checkOutput("s5 async reset dut2", 64'(out2), 64'(RESET_OUT));
    checkOutput("s5 rows before reset", 64'({log1.size(), log2.size()}), 64'({32'd2, 32'd2}));
    @(negedge clk);
    rst = 1'b0;
    runIdle(2);
    checkOutput("s5 no row3 pulse", 64'({log1.size(), log2.size()}), 64'({32'd2, 32'd2}));
    clearLogs();
    applyStimulus(1'b1, 1'b0);
    runIdle(24);
    checkEmits("s5 replay lat1", 1, 1'b0, 0);
    checkEmits("s5 replay lat2", 2, 1'b0, 1);

    // Start accepted from IDLE while paused: playing, but no reads yet.
    $display("[TB] scenario: start while paused");
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearLogs();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("paused start playing", 64'({playing1, playing2, rom_en1}), 64'(3'b111));
    checkOutput("paused start no rows", 64'(log1.size() + log2.size()), 64'd0);
    runIdle(24);
    checkOutput("paused start rows", 64'({log1.size(), log2.size()}), 64'({32'd5, 32'd5}));

    // Random start/pause/reset traffic, checked cycle by cycle against the model.
    $display("[TB] scenario: random traffic");
    pz = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) pz = ~pz;
      applyStimulus(($urandom_range(0, 15) == 0), pz);
    end
    applyStimulus(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
